// File: rtl/div_reconstruct_pkg.sv
// Shared definitions for the dividend-reconstruction unit (N = Q*D + R).
package div_reconstruct_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL   = 3'd2,
    S_ADDR  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/div_reconstruct_dp.sv
// Datapath for div_reconstruct: operand registers, shift-add multiplier,
// remainder adder and the N result register.
module div_reconstruct_dp
  import div_reconstruct_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int NW = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             step,
  input  logic             add_r,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] R,
  output logic [NW-1:0]    N,
  output logic             cnt_last,
  output logic             d_zero,
  output logic             r_ge_d
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] qr, dr, rr;
  logic [NW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [NW-1:0]    d_ext, r_ext;

  assign d_ext    = {{WIDTH{1'b0}}, dr};
  assign r_ext    = {{WIDTH{1'b0}}, rr};
  assign cnt_last = (cnt == CW'(WIDTH - 1));
  assign d_zero   = (dr == '0);
  assign r_ge_d   = (rr >= dr);

  // Worst case (2^W-1)^2 + (2^W-1) fits in NW bits, so no carry out is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      qr  <= '0;
      dr  <= '0;
      rr  <= '0;
      acc <= '0;
      cnt <= '0;
      N   <= '0;
    end else begin
      if (load) begin
        qr <= Q;
        dr <= D;
        rr <= R;
      end
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end
      if (step) begin
        if (qr[0]) acc <= acc + (d_ext << cnt);
        qr  <= qr >> 1;
        cnt <= cnt + CW'(1);
      end
      if (add_r) N <= acc + r_ext;
      if (clr_n) N <= '0;
    end
  end

endmodule

// File: rtl/div_reconstruct.sv
// Rebuilds a dividend N = Q*D + R with a go/done/error handshake; control FSM only.
// Build option: define DIV_RECONSTRUCT_REM_CHECK_EN to also reject R >= D.
module div_reconstruct
  import div_reconstruct_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int NW = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] R,
  output logic [NW-1:0]    N,
  output logic             done,
  output logic             error_flag
);

  state_t state;
  logic   load, clear, step, add_r, clr_n;
  logic   cnt_last, d_zero, r_ge_d, bad_ops;

  assign load  = (state == S_IDLE) && go;
  assign clear = (state == S_CHECK);
  assign step  = (state == S_MUL);
  assign add_r = (state == S_ADDR);
  assign clr_n = (state == S_ERR);

`ifdef DIV_RECONSTRUCT_REM_CHECK_EN
  assign bad_ops = d_zero || r_ge_d;
`else
  assign bad_ops = d_zero;
`endif

  div_reconstruct_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .clear    (clear),
    .step     (step),
    .add_r    (add_r),
    .clr_n    (clr_n),
    .Q        (Q),
    .D        (D),
    .R        (R),
    .N        (N),
    .cnt_last (cnt_last),
    .d_zero   (d_zero),
    .r_ge_d   (r_ge_d)
  );

  // done/error_flag trail the state by one edge, giving done at edge WIDTH+3.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      done       <= (state == S_DONE) || (state == S_ERR);
      error_flag <= (state == S_ERR);
      case (state)
        S_IDLE:  if (go) state <= S_CHECK;
        S_CHECK: state <= bad_ops ? S_ERR : S_MUL;
        S_MUL:   if (cnt_last) state <= S_ADDR;
        S_ADDR:  state <= S_DONE;
        S_DONE:  if (!go) state <= S_IDLE;
        S_ERR:   if (!go) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_reconstruct.sv
// Scoreboard bench for div_reconstruct: expected N/error/latency queued at start,
// compared by an independent monitor on every rising done.
module tb_div_reconstruct;
  localparam int W  = 4;
  localparam int NW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go  = 1'b0;
  logic [W-1:0]  Q = '0, D = '0, R = '0;
  logic [NW-1:0] N;
  logic          done, error_flag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int n;
    int err;
    int lat;
    int start;
  } exp_t;
  exp_t sb[$];

  div_reconstruct #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .go(go), .Q(Q), .D(D), .R(R),
    .N(N), .done(done), .error_flag(error_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int q, input int d, input int r, input int start);
    exp_t e;
    bit bad;
    bad = (d == 0);
`ifdef DIV_RECONSTRUCT_REM_CHECK_EN
    bad = bad || (r >= d);
`endif
    e.err   = bad ? 1 : 0;
    e.n     = bad ? 0 : q * d + r;
    e.lat   = bad ? 2 : W + 3;
    e.start = start;
    return e;
  endfunction

  // Monitor: every rising edge of done must match the oldest queued expectation.
  initial begin
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && pd !== 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("N", int'(N), e.n);
          chk("error_flag", int'(error_flag), e.err);
          chk("latency", cyc - e.start, e.lat);
        end
      end
      pd = done;
    end
  end

  task automatic run_op(input int q, input int d, input int r, input int hold);
    bit   seen;
    exp_t e;
    @(negedge clk);
    Q = q[W-1:0]; D = d[W-1:0]; R = r[W-1:0];
    go = 1'b1;
    e = model(q, d, r, cyc + 1);
    sb.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      Q = W'($urandom); D = W'($urandom); R = W'($urandom);
    end
    chk("done_seen", int'(seen), 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      Q = W'($urandom); D = 3; R = W'($urandom);
      chk("hold_N", int'(N), e.n);
      chk("hold_done", int'(done), 1);
    end
    go = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_release", int'(seen), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_N", int'(N), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(error_flag), 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(3, 5, 2, 0);
    run_op(15, 15, 14, 0);
    run_op(9, 0, 0, 0);
    run_op(4, 5, 6, 0);

    // Reset during MUL: rst sampled low at edge 3.
    run_op(5, 5, 1, 0);
    @(negedge clk);
    Q = 7; D = 3; R = 1; go = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; go = 1'b0;
    @(negedge clk);
    chk("midrst_N", int'(N), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(error_flag), 0);
    rst = 1'b1;
    run_op(7, 3, 1, 0);

    run_op(2, 3, 0, 20);
    run_op(0, 3, 2, 0);

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_reconstruct.md
Name: div_reconstruct

Overview:
- Sequential shift-add unit, inverse of the integer divider: takes a quotient Q, a divisor D and a remainder R, and rebuilds the dividend N = Q*D + R.
- Uses the same go/done/error handshake and control-unit/datapath split as the divider core.
- Sits beside the divider on the FPGA board top. It is driven by the debounced go and manual clock, and N is shown on the 7-segment mux.

Parameters:
- WIDTH, 4, bit width of Q, D and R.
- NW, 2*WIDTH, bit width of N (derived; do not override).

Ports:
- clk  in  1  system clock (manual or divided clock on board).
- rst  in  1  reset; synchronous, active-low.
- go  in  1  start request, level; sampled only in IDLE.
- Q  in  WIDTH  quotient operand.
- D  in  WIDTH  divisor operand.
- R  in  WIDTH  remainder operand.
- N  out  NW  reconstructed dividend.
- done  out  1  operation finished (result or error).
- error_flag  out  1  invalid operands.

Behaviour:
- Reset: rst==0 at a rising clk edge forces state IDLE, N=0, done=0, error_flag=0, and clears all internal registers. This applies in any state, including mid-operation.
- States: IDLE, CHECK, MUL, ADDR, DONE, ERR.
- IDLE:
  - done=0, error_flag=0, N holds its last value.
  - If go==1, register Q, D and R into Qr, Dr and Rr, then go to CHECK.
- CHECK:
  - If Dr==0, go to ERR.
  - Else clear acc (NW bits) and cnt, then go to MUL.
- MUL (WIDTH cycles):
  - If Qr[0]==1, acc <= acc + (Dr << cnt).
  - Qr <= Qr >> 1; cnt <= cnt + 1.
  - Leave for ADDR when cnt==WIDTH-1.
- ADDR: N <= acc + zero-extended Rr; go to DONE.
- DONE: done=1, error_flag=0, N valid; go to IDLE only when go==0.
- ERR: done=1, error_flag=1, N=0; go to IDLE only when go==0.
- Latency: the go-sampling edge is edge 0. done rises at edge WIDTH+3 (7 for WIDTH=4); on the error path it rises at edge 2.
- Width rules:
  - Worst case (2^W-1)^2 + (2^W-1) < 2^NW, so overflow is impossible.
  - All additions are NW bits wide with operands zero-extended.
- Go held high after done: the unit stays in DONE/ERR with no restart. A new operation needs go to drop to 0 and then return to 1.
- Operand or go changes during CHECK, MUL or ADDR are ignored, because the operands are registered at start.
- Q==0: MUL still runs all WIDTH cycles, and N=R.

Optional Feature:
- Macro: DIV_RECONSTRUCT_REM_CHECK_EN.
- Defined: CHECK also routes to ERR when Rr >= Dr (remainder not a legal divider output).
- Undefined: only Dr==0 flags an error, and any R is accepted and added.

Decomposition:
- Shared package:
  - State encoding constants (3-bit: IDLE=0, CHECK=1, MUL=2, ADDR=3, DONE=4, ERR=5).
  - Default WIDTH.
- Natural sub-module: div_reconstruct_dp.
  - Holds the registers Qr/Dr/Rr/acc/cnt, the adder/shifter and the N register.
  - Driven by load/clear/step/add_r strobes and returns cnt_last, d_zero and r_ge_d.
- The top module holds the FSM only.

Test Plan:
- Q=3, D=5, R=2, go pulse -> done=1 exactly 7 edges after the start edge, N=17, error_flag=0.
- Q=15, D=15, R=14 -> N=239, done=1, error_flag=0 (max legal case).
- Q=9, D=0, R=0 -> done=1 and error_flag=1 at edge 2, N=0; releasing go returns to IDLE.
- Q=4, D=5, R=6:
  - With DIV_RECONSTRUCT_REM_CHECK_EN -> error_flag=1, N=0.
  - Without it -> N=26, error_flag=0.
- Start Q=7, D=3, R=1; drive rst=0 at edge 3 (in MUL) -> next edge N=0, done=0, state IDLE. A fresh go then yields N=22.
- Hold go=1 for 20 cycles after done with Q=2, D=3, R=0 -> N=6 stays, no second run. Drop go, then raise it with Q=0, D=3, R=2 -> N=2.
